// File: rtl/regfile_pkg.sv
// Shared definitions for the 2-read/1-write register file with dump engine.
// Holds the dump FSM state type, the default geometry and the one-hot
// write-index decoder used by the top level.
package regfile_pkg;

    // Default geometry: 8 registers of 16 bits.
    localparam int DEF_WIDTH  = 16;
    localparam int DEF_ADDR_W = 3;

    // Upper bound on ADDR_W that the decoder helper supports.
    localparam int MAX_ADDR_W = 8;
    localparam int MAX_REGS   = 1 << MAX_ADDR_W;

    // Dump engine states: idle, or streaming one entry per cycle.
    typedef enum logic [0:0] {
        DUMP_IDLE = 1'b0,
        DUMP_RUN  = 1'b1
    } dump_state_e;

    // Turns an index into a one-hot vector; callers keep the low NREGS bits.
    function automatic logic [MAX_REGS-1:0] onehot_decode(input logic [MAX_ADDR_W-1:0] idx);
        logic [MAX_REGS-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage : regfile_pkg

// File: rtl/regfile_entry.sv
// One register-file entry: a WIDTH-bit load-enabled register that clears
// synchronously on reset. Reset wins over load.
module regfile_entry #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;

    // Hold the stored word; clear on reset, capture d_i when loaded.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every entry samples the pre-edge values.
        if (reset) begin
            data_q <= '0;
        end else if (load_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule : regfile_entry

// File: rtl/regfile_2r1w_dump.sv
// regfile_2r1w_dump: NREGS = 2**ADDR_W entries of WIDTH bits, one write
// port, two combinational read ports (A/B operand paths) and a sequential
// dump engine that streams every entry in index order with valid/last.
// Optional build macro: REGFILE_BYPASS_EN -- when defined, a write in the
// current cycle is forwarded combinationally to any read port (A, B, dump)
// addressing the same index. Undefined (default): reads see stored values.
module regfile_2r1w_dump
    import regfile_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  data_in,
    input  logic [ADDR_W-1:0] writenum,
    input  logic              write,
    input  logic [ADDR_W-1:0] readnum_a,
    input  logic [ADDR_W-1:0] readnum_b,
    output logic [WIDTH-1:0]  data_out_a,
    output logic [WIDTH-1:0]  data_out_b,
    input  logic              dump_start,
    output logic              dump_busy,
    output logic              dump_valid,
    output logic [ADDR_W-1:0] dump_idx,
    output logic [WIDTH-1:0]  dump_data,
    output logic              dump_last
);

    localparam int NREGS = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);

    // ------------------------------------------------------------------
    // Write decode and storage
    // ------------------------------------------------------------------
    logic [MAX_REGS-1:0] wr_onehot;
    logic [NREGS-1:0]    wr_en;
    logic [WIDTH-1:0]    entry_q [NREGS];

    // Decode the write index into per-entry load enables.
    always_comb begin
        wr_onehot = onehot_decode(MAX_ADDR_W'(writenum));
        wr_en     = write ? wr_onehot[NREGS-1:0] : '0;
    end

    // NOTE: the entries are reset on purpose -- the datapath relies on a
    // synchronous clear of every register, so this array is not left as
    // uninitialised RAM.
    for (genvar g = 0; g < NREGS; g++) begin : g_entry
        regfile_entry #(
            .WIDTH (WIDTH)
        ) u_entry (
            .clk    (clk),
            .reset  (reset),
            .load_i (wr_en[g]),
            .d_i    (data_in),
            .q_o    (entry_q[g])
        );
    end

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] stored_a;
    logic [WIDTH-1:0] stored_b;

    assign stored_a = entry_q[readnum_a];
    assign stored_b = entry_q[readnum_b];

`ifdef REGFILE_BYPASS_EN
    // Forward same-cycle write data to a read port addressing the written entry.
    always_comb begin
        data_out_a = (write && (writenum == readnum_a)) ? data_in : stored_a;
        data_out_b = (write && (writenum == readnum_b)) ? data_in : stored_b;
    end
`else
    // Reads return the stored value; a same-cycle write lands at the edge.
    always_comb begin
        data_out_a = stored_a;
        data_out_b = stored_b;
    end
`endif

    // ------------------------------------------------------------------
    // Dump engine
    // ------------------------------------------------------------------
    dump_state_e       state_q, state_d;
    logic [ADDR_W-1:0] idx_q,   idx_d;
    logic              at_last;

    assign at_last = (idx_q == LAST_IDX);

    // Next-state logic: start only from idle, stop after the last index.
    always_comb begin
        // NOTE: defaults first so no path through the case leaves a latch.
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            DUMP_IDLE: begin
                if (dump_start) begin
                    state_d = DUMP_RUN;
                    idx_d   = '0;
                end
            end
            DUMP_RUN: begin
                if (at_last) begin
                    state_d = DUMP_IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = DUMP_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // State and index registers; reset aborts any dump in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= DUMP_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    logic             running;
    logic [WIDTH-1:0] dump_stored;

    assign running     = (state_q == DUMP_RUN);
    assign dump_stored = entry_q[idx_q];

    // Dump outputs: live only while running, all zero otherwise.
    always_comb begin
        dump_busy  = running;
        dump_valid = running;
        dump_idx   = running ? idx_q : '0;
        dump_last  = running && at_last;
        dump_data  = '0;
        if (running) begin
`ifdef REGFILE_BYPASS_EN
            dump_data = (write && (writenum == idx_q)) ? data_in : dump_stored;
`else
            dump_data = dump_stored;
`endif
        end
    end

endmodule : regfile_2r1w_dump

// File: tb/tb_regfile_2r1w_dump.sv
// Self-checking bench for regfile_2r1w_dump: directed test-plan steps then
// random traffic, all compared against a behavioural model held here.
module tb_regfile_2r1w_dump;

    localparam int WIDTH  = 16;
    localparam int ADDR_W = 3;
    localparam int NREGS  = 8;

    logic              clk;
    logic              reset;
    logic [WIDTH-1:0]  data_in;
    logic [ADDR_W-1:0] writenum;
    logic              write;
    logic [ADDR_W-1:0] readnum_a;
    logic [ADDR_W-1:0] readnum_b;
    logic [WIDTH-1:0]  data_out_a;
    logic [WIDTH-1:0]  data_out_b;
    logic              dump_start;
    logic              dump_busy;
    logic              dump_valid;
    logic [ADDR_W-1:0] dump_idx;
    logic [WIDTH-1:0]  dump_data;
    logic              dump_last;

    regfile_2r1w_dump #(
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .writenum   (writenum),
        .write      (write),
        .readnum_a  (readnum_a),
        .readnum_b  (readnum_b),
        .data_out_a (data_out_a),
        .data_out_b (data_out_b),
        .dump_start (dump_start),
        .dump_busy  (dump_busy),
        .dump_valid (dump_valid),
        .dump_idx   (dump_idx),
        .dump_data  (dump_data),
        .dump_last  (dump_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: register contents plus position in the current dump
    // (-1 when no dump is running).
    logic [WIDTH-1:0] mem [NREGS];
    int               pos;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] model_read(input int idx);
        if (BYPASS && write && (int'(writenum) == idx)) return data_in;
        return mem[idx];
    endfunction

    // Compare every output against the model for the inputs now applied.
    task automatic check_all(input string tag);
        bit busy;
        busy = (pos >= 0);
        check({tag, ".a"},     32'(data_out_a), 32'(model_read(int'(readnum_a))));
        check({tag, ".b"},     32'(data_out_b), 32'(model_read(int'(readnum_b))));
        check({tag, ".busy"},  32'(dump_busy),  32'(busy));
        check({tag, ".valid"}, 32'(dump_valid), 32'(busy));
        check({tag, ".idx"},   32'(dump_idx),   busy ? 32'(pos) : 32'd0);
        check({tag, ".data"},  32'(dump_data),  busy ? 32'(model_read(pos)) : 32'd0);
        check({tag, ".last"},  32'(dump_last),  32'(busy && pos == NREGS - 1));
    endtask

    // Advance one clock: update the model from the applied inputs, then the DUT.
    task automatic tick();
        if (reset) begin
            for (int i = 0; i < NREGS; i++) mem[i] = '0;
            pos = -1;
        end else begin
            if (write) mem[writenum] = data_in;
            if (pos < 0) begin
                if (dump_start) pos = 0;
            end else if (pos == NREGS - 1) begin
                pos = -1;
            end else begin
                pos = pos + 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset      = 1'b0;
        write      = 1'b0;
        dump_start = 1'b0;
        data_in    = '0;
        writenum   = '0;
        readnum_a  = '0;
        readnum_b  = '0;
    endtask

    initial begin
        int valid_cycles;
        idle_inputs();
        for (int i = 0; i < NREGS; i++) mem[i] = 'x;
        pos = -1;
        @(posedge clk);
        #1;

        // Reset, then every index reads zero on both ports.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            readnum_a = ADDR_W'(i);
            readnum_b = ADDR_W'(i);
            #1;
            check("rst_rd_a", 32'(data_out_a), 32'h0);
            check("rst_rd_b", 32'(data_out_b), 32'h0);
        end
        check("rst_busy", 32'(dump_busy), 32'h0);
        check("rst_idx",  32'(dump_idx),  32'h0);

        // Write R3 then R7; read during the R3 write shows old value or bypass.
        write = 1'b1; writenum = 3'd3; data_in = 16'hA5A5; readnum_a = 3'd3;
        #1;
        check("rdw_r3", 32'(data_out_a), BYPASS ? 32'hA5A5 : 32'h0);
        tick();
        writenum = 3'd7; data_in = 16'h1234;
        tick();
        write = 1'b0; readnum_a = 3'd3; readnum_b = 3'd7;
        #1;
        check("wr_r3", 32'(data_out_a), 32'hA5A5);
        check("wr_r7", 32'(data_out_b), 32'h1234);

        // Load 0x0100+i everywhere and run one full dump.
        for (int i = 0; i < NREGS; i++) begin
            write = 1'b1; writenum = ADDR_W'(i); data_in = 16'(16'h0100 + i);
            tick();
        end
        write = 1'b0;
        dump_start = 1'b1;
        #1;
        check("dump_pre_valid", 32'(dump_valid), 32'h0);
        tick();
        dump_start = 1'b0;
        valid_cycles = 0;
        for (int c = 0; c < NREGS + 2; c++) begin
            #1;
            if (c < NREGS) begin
                check("dump_idx",  32'(dump_idx),  32'(c));
                check("dump_data", 32'(dump_data), 32'(16'h0100 + c));
                check("dump_last", 32'(dump_last), 32'(c == NREGS - 1));
            end
            check_all("dump1");
            if (dump_valid) valid_cycles++;
            tick();
        end
        check("dump_len", 32'(valid_cycles), 32'(NREGS));

        // Write R5 and re-request mid-dump; new value streams, no second dump.
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        tick();
        tick();
        #1;
        check("mid_idx2", 32'(dump_idx), 32'h2);
        write = 1'b1; writenum = 3'd5; data_in = 16'hBEEF; dump_start = 1'b1;
        check_all("mid_wr");
        tick();
        write = 1'b0; dump_start = 1'b0;
        valid_cycles = 3;
        for (int c = 3; c < NREGS + 3; c++) begin
            #1;
            if (c == 5) check("mid_r5", 32'(dump_data), 32'hBEEF);
            check_all("dump2");
            if (dump_valid) valid_cycles++;
            tick();
        end
        check("dump2_len",  32'(valid_cycles), 32'(NREGS));
        check("dump2_idle", 32'(dump_busy), 32'h0);

        // Reset at idx 4 aborts the dump and clears R1.
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        #1;
        check("abort_idx4", 32'(dump_idx), 32'h4);
        readnum_a = 3'd1;
        #1;
        check("abort_r1_pre", 32'(data_out_a), 32'h0101);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("abort_valid", 32'(dump_valid), 32'h0);
        check("abort_idx",   32'(dump_idx),   32'h0);
        check("abort_busy",  32'(dump_busy),  32'h0);
        check("abort_r1",    32'(data_out_a), 32'h0);

        // Reset beats a simultaneous write.
        reset = 1'b1; write = 1'b1; writenum = 3'd2; data_in = 16'hFFFF;
        tick();
        idle_inputs();
        readnum_b = 3'd2;
        #1;
        check("rst_wr_r2", 32'(data_out_b), 32'h0);

        // Random traffic against the model.
        for (int c = 0; c < 400; c++) begin
            reset      = ($urandom_range(0, 49) == 0);
            write      = ($urandom_range(0, 1) == 1);
            writenum   = ADDR_W'($urandom_range(0, NREGS - 1));
            data_in    = WIDTH'($urandom);
            readnum_a  = ADDR_W'($urandom_range(0, NREGS - 1));
            readnum_b  = ($urandom_range(0, 3) == 0) ? writenum : ADDR_W'($urandom_range(0, NREGS - 1));
            dump_start = ($urandom_range(0, 5) == 0);
            #1;
            check_all("rand");
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_regfile_2r1w_dump
